alu_iterative_exec: RTL



---
 rtl/alu_iterative_exec_pkg.sv | 25 ++
 rtl/alu_iterative_exec_comb_ops.sv | 31 +++
 rtl/alu_iterative_exec.sv | 110 +++++++++++
 3 files changed

// File: rtl/alu_iterative_exec_pkg.sv
// Shared op codes, FSM state type and decode helpers for the iterative execute unit.
// Codes follow the RV32I {funct7[5], funct3} packing used by the ALU decoder.
package alu_iterative_exec_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_iterative_exec_comb_ops.sv
// Single-cycle ops (ADD/SUB/AND/OR/XOR/SLT/SLTU) plus legal-code detection.
// Shift codes are reported legal here but return 0; the top sequences them.
module alu_comb_ops
    import alu_iterative_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] res,
    output logic            legal
);

    always_comb begin
        res   = '0;
        legal = 1'b1;
        case (op)
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_SLL, ALU_SRL, ALU_SRA: res = '0;
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_iterative_exec.sv
// Multi-cycle execute unit: logic/arith ops in 1 cycle, shifts via 1-bit/cycle serial shifter (s+1 cycles).
// start is sampled only while busy=0; requests during a shift are dropped.
module alu_iterative_exec
    import alu_iterative_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SW = $clog2(XLEN);

    state_t          state, state_nxt;
    logic [XLEN-1:0] sh_reg, sh_next, comb_res;
    logic [SW-1:0]   cnt, shamt;
    logic [3:0]      op_q;
    logic            comb_legal, start_shift;

    alu_comb_ops #(.XLEN(XLEN)) u_comb (
        .op    (alu_control),
        .a     (a),
        .b     (b),
        .res   (comb_res),
        .legal (comb_legal)
    );

    assign shamt       = b[SW-1:0];
    assign start_shift = is_shift_op(alu_control) && (shamt != '0);
    assign busy        = (state == SHIFT);

    // SRA keeps the sign bit in place, so the MSB always holds the original bit XLEN-1.
    always_comb begin
        case (op_q)
            ALU_SLL: sh_next = {sh_reg[XLEN-2:0], 1'b0};
            ALU_SRL: sh_next = {1'b0, sh_reg[XLEN-1:1]};
            default: sh_next = {sh_reg[XLEN-1], sh_reg[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && start_shift) state_nxt = SHIFT;
            SHIFT:   if (cnt == SW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_reg  <= '0;
            cnt     <= '0;
            op_q    <= ALU_ADD;
            done    <= 1'b0;
            result  <= '0;
            zero    <= 1'b1;
            illegal <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_shift) begin
                            sh_reg <= a;
                            cnt    <= shamt;
                            op_q   <= alu_control;
                        end else if (is_shift_op(alu_control)) begin
                            result  <= a;
                            zero    <= (a == '0);
                            illegal <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            result  <= comb_res;
                            zero    <= (comb_res == '0);
                            illegal <= ~comb_legal;
                            done    <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    sh_reg <= sh_next;
                    cnt    <= cnt - SW'(1);
                    if (cnt == SW'(1)) begin
                        result  <= sh_next;
                        zero    <= (sh_next == '0);
                        illegal <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
